// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// sdram_arb_pkg : shared types and SDRAM map constants for the port arbiter
// Rev 1.0
// ============================================================================
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

    // SDRAM word map: LCD GRAM frame first, photon-counter buffer right after it
    localparam int GRAM_BASE = 0;
    localparam int GRAM_LEN  = 384000;
    localparam int PCNT_BASE = 384000;
    localparam int PCNT_LEN  = 600;

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : combinational round-robin picker, searching from last_grant+1
// Rev 1.0
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_req_o
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // Offset 1 first, so the previous winner is considered last
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(last_grant_i) + i) % NUM_REQ);
            if (!w_found && req_i[w_idx]) begin
                grant_o = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_port_arbiter : round-robin sharing of the SDRAM glue port between
// NUM_REQ level-handshake requesters, with a done-timeout watchdog.
// Rev 1.0
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic [NUM_REQ-1:0]           req_rd_i,
    input  logic [NUM_REQ-1:0]           req_wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_rd_addr_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_wr_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wr_data_i,
    output logic [NUM_REQ-1:0]           rd_done_o,
    output logic [NUM_REQ-1:0]           wr_done_o,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         sdram_rd_req_o,
    output logic [ADDR_W-1:0]            sdram_rd_addr_o,
    input  logic [DATA_W-1:0]            sdram_rd_data_i,
    input  logic                         sdram_rd_done_i,
    output logic                         sdram_wr_req_o,
    output logic [ADDR_W-1:0]            sdram_wr_addr_o,
    output logic [DATA_W-1:0]            sdram_wr_data_o,
    input  logic                         sdram_wr_done_i,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
    output logic                         busy_o,
    output logic                         timeout_err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic               op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [NUM_REQ-1:0] rd_done_q, rd_done_d;
    logic [NUM_REQ-1:0] wr_done_q, wr_done_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               timeout_err_q, timeout_err_d;

    logic [IDX_W-1:0]   w_pick;
    logic               w_any_req;
    logic               w_match;
    logic               w_expire;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_i        (req_rd_i | req_wr_i),
        .last_grant_i (last_grant_q),
        .grant_o      (w_pick),
        .any_req_o    (w_any_req)
    );

    assign w_match  = op_wr_q ? sdram_wr_done_i : sdram_rd_done_i;
    assign w_expire = (wdog_q == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        op_wr_d       = op_wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wdog_d        = wdog_q;
        rd_done_d     = '0;
        wr_done_d     = '0;
        rd_data_d     = rd_data_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (en_i && w_any_req) begin
                    grant_id_d   = w_pick;
                    last_grant_d = w_pick;
                    // A requester holding both levels gets its write first
                    op_wr_d      = req_wr_i[w_pick];
                    addr_d       = req_wr_i[w_pick]
                                 ? req_wr_addr_i[w_pick*ADDR_W +: ADDR_W]
                                 : req_rd_addr_i[w_pick*ADDR_W +: ADDR_W];
                    wdata_d      = req_wr_data_i[w_pick*DATA_W +: DATA_W];
                    wdog_d       = '0;
                    state_d      = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (w_match || w_expire) begin
                    state_d = ST_RELEASE;
                    if (op_wr_q) begin
                        wr_done_d[grant_id_q] = 1'b1;
                    end else begin
                        rd_done_d[grant_id_q] = 1'b1;
                        rd_data_d = w_match ? sdram_rd_data_i : '0;
                    end
                    if (!w_match) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            // One dead cycle lets the served requester drop req before the next pick
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            op_wr_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wdog_q        <= '0;
            rd_done_q     <= '0;
            wr_done_q     <= '0;
            rd_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            op_wr_q       <= op_wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wdog_q        <= wdog_d;
            rd_done_q     <= rd_done_d;
            wr_done_q     <= wr_done_d;
            rd_data_q     <= rd_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign sdram_rd_req_o  = (state_q == ST_ACTIVE) && !op_wr_q;
    assign sdram_wr_req_o  = (state_q == ST_ACTIVE) &&  op_wr_q;
    assign sdram_rd_addr_o = addr_q;
    assign sdram_wr_addr_o = addr_q;
    assign sdram_wr_data_o = wdata_q;
    assign rd_done_o       = rd_done_q;
    assign wr_done_o       = wr_done_q;
    assign rd_data_o       = rd_data_q;
    assign grant_id_o      = grant_id_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign timeout_err_o   = timeout_err_q;

endmodule
`default_nettype wire
